bcd_tick_counter: RTL and testbench

- Parametrised successor to the single-digit seconds display: a multi-digit BCD counter advanced by an internal prescaler tick.
- Each digit drives its own active-low seven-segment output.
- Adds enable, synchronous clear, up/down mode, and tick/wrap status pulses.
- Sits between the board clock and the HEX displays; it is the standard timebase-plus-display block for later labs (stopwatch, clock, timer).

---
 rtl/bcd_tick_counter.sv | 123 ++++++++++++
 tb/tb_bcd_tick_counter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler tick, with per-digit
// active-low seven-segment outputs. Define BCD_TICK_BLANK_EN for leading-zero blanking.
module bcd_tick_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  Resetn,
  input  logic                  En,
  input  logic                  Clr,
  input  logic                  Down,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  Tick,
  output logic                  Wrap
);

  if (DIGITS < 1 || DIGITS > 8 || TICK_DIV < 1) begin : g_param_check
    $error("bcd_tick_counter: DIGITS must be 1..8 and TICK_DIV must be >= 1");
  end

  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]             presc;
  logic [DIGITS-1:0][3:0]    digit_q;
  logic [DIGITS-1:0][3:0]    digit_nxt;
  logic                      carry;
  logic                      roll;

  // Ripple carry/borrow through all digits; carry surviving the top digit means rollover.
  always_comb begin
    digit_nxt = digit_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (Down) begin
          if (digit_q[i] == 4'd0) begin
            digit_nxt[i] = 4'd9;
          end else begin
            digit_nxt[i] = (digit_q[i] > 4'd9) ? 4'd8 : digit_q[i] - 4'd1;
            carry        = 1'b0;
          end
        end else begin
          if (digit_q[i] >= 4'd9) begin
            digit_nxt[i] = 4'd0;
          end else begin
            digit_nxt[i] = digit_q[i] + 4'd1;
            carry        = 1'b0;
          end
        end
      end
    end
    roll = carry;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      presc   <= '0;
      digit_q <= '0;
      Tick    <= 1'b0;
      Wrap    <= 1'b0;
    end else if (Clr) begin
      presc   <= '0;
      digit_q <= '0;
      Tick    <= 1'b0;
      Wrap    <= 1'b0;
    end else if (En) begin
      if (presc == LAST) begin
        presc   <= '0;
        digit_q <= digit_nxt;
        Tick    <= 1'b1;
        Wrap    <= roll;
      end else begin
        presc   <= presc + PW'(1);
        Tick    <= 1'b0;
        Wrap    <= 1'b0;
      end
    end else begin
      Tick <= 1'b0;
      Wrap <= 1'b0;
    end
  end

  assign BCD = digit_q;

  // Segment order a..g from MSB to LSB, 0 = lit; out-of-range codes go dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0001100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

`ifdef BCD_TICK_BLANK_EN
  logic lead;
  always_comb begin
    HEX  = '1;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead          = lead & (digit_q[i] == 4'd0);
      HEX[7*i +: 7] = (i > 0 && lead) ? 7'b1111111 : seg7(digit_q[i]);
    end
  end
`else
  always_comb begin
    HEX = '1;
    for (int i = 0; i < DIGITS; i++) begin
      HEX[7*i +: 7] = seg7(digit_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench: two-digit counter with TICK_DIV=4, plus a one-digit counter with TICK_DIV=1.
module tb_bcd_tick_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, en_a, clr_a, down_a, en_b, clr_b, down_b;
  logic [7:0]  bcd_a;
  logic [13:0] hex_a;
  logic        tick_a, wrap_a;
  logic [3:0]  bcd_b;
  logic [6:0]  hex_b;
  logic        tick_b, wrap_b;

  int tests = 0;
  int fails = 0;

  bcd_tick_counter #(.DIGITS(2), .TICK_DIV(4)) dut_a (
    .CLOCK_50(clk), .Resetn(resetn), .En(en_a), .Clr(clr_a), .Down(down_a),
    .BCD(bcd_a), .HEX(hex_a), .Tick(tick_a), .Wrap(wrap_a)
  );

  bcd_tick_counter #(.DIGITS(1), .TICK_DIV(1)) dut_b (
    .CLOCK_50(clk), .Resetn(resetn), .En(en_b), .Clr(clr_b), .Down(down_b),
    .BCD(bcd_b), .HEX(hex_b), .Tick(tick_b), .Wrap(wrap_b)
  );

  logic [6:0] seg_tab [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };

  function automatic logic [7:0] exp_bcd(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [13:0] exp_hex(int n);
    logic [6:0] hi;
    hi = seg_tab[n / 10];
`ifdef BCD_TICK_BLANK_EN
    if (n / 10 == 0) hi = 7'b1111111;
`endif
    return {hi, seg_tab[n % 10]};
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(string tag, int n, logic t, logic w);
    chk({tag, "_bcd"},  32'(bcd_a),  32'(exp_bcd(n)));
    chk({tag, "_hex"},  32'(hex_a),  32'(exp_hex(n)));
    chk({tag, "_tick"}, 32'(tick_a), 32'(t));
    chk({tag, "_wrap"}, 32'(wrap_a), 32'(w));
  endtask

  initial begin
    resetn = 1'b0; en_a = 1'b0; clr_a = 1'b0; down_a = 1'b0;
    en_b = 1'b0; clr_b = 1'b0; down_b = 1'b0;
    cyc(2);
    chk_a("reset", 0, 1'b0, 1'b0);
    resetn = 1'b1;
    en_a   = 1'b1;

    // Up count to 37: one tick every 4 cycles, carry at the 10th tick.
    for (int k = 1; k <= 37; k++) begin
      cyc(3);
      chk("up_gap_tick", 32'(tick_a), 32'd0);
      cyc(1);
      chk_a("up", k, 1'b1, 1'b0);
    end

    // Asynchronous reset between edges while Tick is high.
    #2 resetn = 1'b0;
    #1 chk_a("rst_mid", 0, 1'b0, 1'b0);
    cyc(1);
    resetn = 1'b1;

    for (int k = 1; k <= 99; k++) begin
      cyc(4);
      chk_a("up99", k, 1'b1, 1'b0);
    end
    cyc(4);
    chk_a("roll_up", 0, 1'b1, 1'b1);
    cyc(1);
    chk_a("roll_up_after", 0, 1'b0, 1'b0);

    // Clear resynchronises the prescaler, then count down through rollover.
    clr_a = 1'b1;
    cyc(1);
    chk_a("clr", 0, 1'b0, 1'b0);
    clr_a  = 1'b0;
    down_a = 1'b1;
    cyc(4);
    chk_a("roll_dn", 99, 1'b1, 1'b1);
    for (int k = 98; k >= 10; k--) begin
      cyc(4);
      chk_a("down", k, 1'b1, 1'b0);
    end
    cyc(4);
    chk_a("borrow", 9, 1'b1, 1'b0);

    // Direction change between steps takes effect on the next step.
    cyc(2);
    down_a = 1'b0;
    cyc(2);
    chk_a("dir_late", 10, 1'b1, 1'b0);

    // Enable drop at P=2 holds everything.
    cyc(2);
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk_a("hold", 10, 1'b0, 1'b0);
    end
    en_a = 1'b1;
    cyc(1);
    chk_a("resume1", 10, 1'b0, 1'b0);
    cyc(1);
    chk_a("resume2", 11, 1'b1, 1'b0);

    // Clear wins over enable at P=3 and restarts the prescaler.
    cyc(3);
    clr_a = 1'b1;
    cyc(1);
    chk_a("clr_en", 0, 1'b0, 1'b0);
    clr_a = 1'b0;
    cyc(3);
    chk_a("after_clr_gap", 0, 1'b0, 1'b0);
    cyc(1);
    chk_a("after_clr", 1, 1'b1, 1'b0);

    // TICK_DIV=1, one digit: step every enabled cycle.
    chk("b_idle_bcd", 32'(bcd_b), 32'd0);
    en_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk("b_bcd",  32'(bcd_b),  32'(k % 10));
      chk("b_hex",  32'(hex_b),  32'(seg_tab[k % 10]));
      chk("b_tick", 32'(tick_b), 32'd1);
      chk("b_wrap", 32'(wrap_b), (k % 10 == 0) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
